inst_queue: RTL and testbench

- Dual-issue instruction buffer between the fetch stage and the decode stage.
- Accepts 0–2 fetched instructions per cycle from IF, each with its pc, instruction word, branch prediction and fetch exception.
- Presents the oldest two entries to ID as lanes a/b.
- Retires 0–2 entries per cycle according to ID's id_consume_inst count. This block is the producer end of the a_*/b_*/id_consume_inst interface.

---
 rtl/inst_queue_pkg.sv | 25 ++
 rtl/inst_queue.sv | 126 ++++++++++++
 tb/tb_inst_queue.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch/decode instruction buffer: fetch exception codes
// and the per-entry record stored in the queue.
package inst_queue_pkg;

  typedef enum logic [3:0] {
    EXC_NONE = 4'd0,
    ADEF     = 4'd1,
    ALE      = 4'd2,
    SYS      = 4'd3,
    BRK      = 4'd4,
    INE      = 4'd5,
    IPE      = 4'd6,
    TLBR     = 4'd7
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_branch_taken;
    logic [31:0] pred_branch_target;
    logic        have_exception;
    exception_t  exception_type;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Dual-issue instruction buffer between IF and ID: up to two pushes and two
// retirements per cycle, oldest two entries presented combinationally as lanes a/b.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  output logic        iq_allowin,
  input  logic [1:0]  if_push_num,
  input  logic [31:0] if_a_pc,
  input  logic [31:0] if_b_pc,
  input  logic [31:0] if_a_inst,
  input  logic [31:0] if_b_inst,
  input  logic        if_a_pred_branch_taken,
  input  logic        if_b_pred_branch_taken,
  input  logic [31:0] if_a_pred_branch_target,
  input  logic [31:0] if_b_pred_branch_target,
  input  logic        if_a_have_exception,
  input  logic        if_b_have_exception,
  input  exception_t  if_a_exception_type,
  input  exception_t  if_b_exception_type,
  input  logic [1:0]  id_consume_inst,
  output logic        a_valid,
  output logic        b_valid,
  output logic [31:0] a_pc,
  output logic [31:0] a_inst,
  output logic        a_pred_branch_taken,
  output logic [31:0] a_pred_branch_target,
  output logic        a_have_exception,
  output exception_t  a_exception_type,
  output logic [31:0] b_pc,
  output logic [31:0] b_inst,
  output logic        b_pred_branch_taken,
  output logic [31:0] b_pred_branch_target,
  output logic        b_have_exception,
  output exception_t  b_exception_type
);

  localparam int unsigned IQ_PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W    = IQ_PTR_W + 1;

  logic [IQ_PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  iq_entry_t           entries_q [DEPTH];
  logic [1:0]          push_acc, pop_eff;
  iq_entry_t           wr_a, wr_b, rd_a, rd_b;

  // Registered count only, so consumption never feeds back into allowin.
  assign iq_allowin = (count_q <= CNT_W'(DEPTH - 2));

  assign wr_a = '{pc: if_a_pc, inst: if_a_inst,
                  pred_branch_taken: if_a_pred_branch_taken,
                  pred_branch_target: if_a_pred_branch_target,
                  have_exception: if_a_have_exception,
                  exception_type: if_a_exception_type};
  assign wr_b = '{pc: if_b_pc, inst: if_b_inst,
                  pred_branch_taken: if_b_pred_branch_taken,
                  pred_branch_target: if_b_pred_branch_target,
                  have_exception: if_b_have_exception,
                  exception_type: if_b_exception_type};

  always_comb begin
    push_acc = '0;
    pop_eff  = '0;
    if (iq_allowin && (if_push_num != 2'd3)) push_acc = if_push_num;
    if (id_consume_inst != 2'd3) begin
      // A consume beyond the occupancy can only happen with count <= 1.
      if (CNT_W'(id_consume_inst) > count_q) pop_eff = count_q[1:0];
      else                                   pop_eff = id_consume_inst;
    end
    head_d  = head_q + IQ_PTR_W'(pop_eff);
    tail_d  = tail_q + IQ_PTR_W'(push_acc);
    count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_eff);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (!flush) begin
        if (push_acc != 2'd0) entries_q[tail_q] <= wr_a;
        if (push_acc == 2'd2) entries_q[tail_q + IQ_PTR_W'(1)] <= wr_b;
      end
    end
  end

  assign rd_a = entries_q[head_q];
  assign rd_b = entries_q[head_q + IQ_PTR_W'(1)];

  assign a_valid              = (count_q != '0);
  assign b_valid              = (count_q >= CNT_W'(2));
  assign a_pc                 = rd_a.pc;
  assign a_inst               = rd_a.inst;
  assign a_pred_branch_taken  = rd_a.pred_branch_taken;
  assign a_pred_branch_target = rd_a.pred_branch_target;
  assign a_have_exception     = rd_a.have_exception;
  assign a_exception_type     = rd_a.exception_type;
  assign b_pc                 = rd_b.pc;
  assign b_inst               = rd_b.inst;
  assign b_pred_branch_taken  = rd_b.pred_branch_taken;
  assign b_pred_branch_target = rd_b.pred_branch_target;
  assign b_have_exception     = rd_b.have_exception;
  assign b_exception_type     = rd_b.exception_type;

  a_push_num_legal: assert property (@(posedge clk) disable iff (reset)
    if_push_num != 2'd3);
  a_consume_legal: assert property (@(posedge clk) disable iff (reset || flush)
    id_consume_inst != 2'd3);
  a_consume_le_count: assert property (@(posedge clk) disable iff (reset || flush)
    CNT_W'(id_consume_inst) <= count_q);

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8): push/pop, full, wrap, flush,
// field pass-through and asynchronous reset.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        iq_allowin;
  logic [1:0]  if_push_num;
  logic [31:0] if_a_pc, if_b_pc, if_a_inst, if_b_inst;
  logic        if_a_pred_branch_taken, if_b_pred_branch_taken;
  logic [31:0] if_a_pred_branch_target, if_b_pred_branch_target;
  logic        if_a_have_exception, if_b_have_exception;
  exception_t  if_a_exception_type, if_b_exception_type;
  logic [1:0]  id_consume_inst;
  logic        a_valid, b_valid;
  logic [31:0] a_pc, a_inst, a_pred_branch_target;
  logic        a_pred_branch_taken, a_have_exception;
  exception_t  a_exception_type;
  logic [31:0] b_pc, b_inst, b_pred_branch_target;
  logic        b_pred_branch_taken, b_have_exception;
  exception_t  b_exception_type;

  int checks = 0;
  int errors = 0;

  inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .iq_allowin(iq_allowin),
    .if_push_num(if_push_num),
    .if_a_pc(if_a_pc), .if_b_pc(if_b_pc),
    .if_a_inst(if_a_inst), .if_b_inst(if_b_inst),
    .if_a_pred_branch_taken(if_a_pred_branch_taken),
    .if_b_pred_branch_taken(if_b_pred_branch_taken),
    .if_a_pred_branch_target(if_a_pred_branch_target),
    .if_b_pred_branch_target(if_b_pred_branch_target),
    .if_a_have_exception(if_a_have_exception),
    .if_b_have_exception(if_b_have_exception),
    .if_a_exception_type(if_a_exception_type),
    .if_b_exception_type(if_b_exception_type),
    .id_consume_inst(id_consume_inst),
    .a_valid(a_valid), .b_valid(b_valid),
    .a_pc(a_pc), .a_inst(a_inst),
    .a_pred_branch_taken(a_pred_branch_taken),
    .a_pred_branch_target(a_pred_branch_target),
    .a_have_exception(a_have_exception), .a_exception_type(a_exception_type),
    .b_pc(b_pc), .b_inst(b_inst),
    .b_pred_branch_taken(b_pred_branch_taken),
    .b_pred_branch_target(b_pred_branch_target),
    .b_have_exception(b_have_exception), .b_exception_type(b_exception_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  task automatic idle();
    if_push_num             = 2'd0;
    id_consume_inst         = 2'd0;
    flush                   = 1'b0;
    if_a_pc                 = '0;
    if_b_pc                 = '0;
    if_a_inst               = '0;
    if_b_inst               = '0;
    if_a_pred_branch_taken  = 1'b0;
    if_b_pred_branch_taken  = 1'b0;
    if_a_pred_branch_target = '0;
    if_b_pred_branch_target = '0;
    if_a_have_exception     = 1'b0;
    if_b_have_exception     = 1'b0;
    if_a_exception_type     = EXC_NONE;
    if_b_exception_type     = EXC_NONE;
  endtask

  // One clock: apply push/consume/flush, step past the edge, return inputs to idle.
  task automatic cyc(input logic [1:0] pnum, input logic [31:0] pca, input logic [31:0] pcb,
                     input logic [1:0] cons, input logic fl);
    if_push_num     = pnum;
    if_a_pc         = pca;
    if_b_pc         = pcb;
    if_a_inst       = inst_of(pca);
    if_b_inst       = inst_of(pcb);
    id_consume_inst = cons;
    flush           = fl;
    @(posedge clk);
    #1;
    idle();
  endtask

  logic [31:0] base;

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_allowin", 32'(iq_allowin), 32'd1);
    check("rst_a_pc", a_pc, 32'd0);
    reset = 1'b0;

    // Basic push of two
    cyc(2'd2, 32'h1c000000, 32'h1c000004, 2'd0, 1'b0);
    check("t1_a_valid", 32'(a_valid), 32'd1);
    check("t1_b_valid", 32'(b_valid), 32'd1);
    check("t1_a_pc", a_pc, 32'h1c000000);
    check("t1_b_pc", b_pc, 32'h1c000004);
    check("t1_a_inst", a_inst, inst_of(32'h1c000000));
    check("t1_allowin", 32'(iq_allowin), 32'd1);

    // Fill to DEPTH, then a refused push
    cyc(2'd2, 32'h1c000008, 32'h1c00000c, 2'd0, 1'b0);
    cyc(2'd2, 32'h1c000010, 32'h1c000014, 2'd0, 1'b0);
    check("t2_allowin_cnt6", 32'(iq_allowin), 32'd1);
    cyc(2'd2, 32'h1c000018, 32'h1c00001c, 2'd0, 1'b0);
    check("t2_allowin_cnt8", 32'(iq_allowin), 32'd0);
    cyc(2'd2, 32'h1c000020, 32'h1c000024, 2'd0, 1'b0);
    check("t2_full_a_pc", a_pc, 32'h1c000000);
    check("t2_full_allowin", 32'(iq_allowin), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("t2_drain_a_pc", a_pc, 32'h1c000000 + 32'(8 * k));
      check("t2_drain_b_pc", b_pc, 32'h1c000004 + 32'(8 * k));
      cyc(2'd0, '0, '0, 2'd2, 1'b0);
    end
    check("t2_empty_a_valid", 32'(a_valid), 32'd0);
    check("t2_empty_b_valid", 32'(b_valid), 32'd0);
    check("t2_empty_allowin", 32'(iq_allowin), 32'd1);

    // Wrap: head reaches 7 with tail at 2
    base = 32'h1c000200;
    cyc(2'd2, base + 32'd0,  base + 32'd4,  2'd0, 1'b0);
    cyc(2'd2, base + 32'd8,  base + 32'd12, 2'd1, 1'b0);
    cyc(2'd2, base + 32'd16, base + 32'd20, 2'd2, 1'b0);
    cyc(2'd2, base + 32'd24, base + 32'd28, 2'd2, 1'b0);
    cyc(2'd2, base + 32'd32, base + 32'd36, 2'd2, 1'b0);
    check("t3_a_valid", 32'(a_valid), 32'd1);
    check("t3_b_valid", 32'(b_valid), 32'd1);
    check("t3_wrap_a_pc", a_pc, base + 32'd28);
    check("t3_wrap_b_pc", b_pc, base + 32'd32);
    cyc(2'd0, '0, '0, 2'd2, 1'b0);
    check("t3_cnt1_a_valid", 32'(a_valid), 32'd1);
    check("t3_cnt1_b_valid", 32'(b_valid), 32'd0);
    check("t3_cnt1_a_pc", a_pc, base + 32'd36);
    cyc(2'd0, '0, '0, 2'd1, 1'b0);

    // Simultaneous push 2 / consume 2 at count 2
    base = 32'h1c000400;
    cyc(2'd2, base + 32'd0, base + 32'd4, 2'd0, 1'b0);
    cyc(2'd2, base + 32'd8, base + 32'd12, 2'd2, 1'b0);
    check("t4_b_valid", 32'(b_valid), 32'd1);
    check("t4_a_pc", a_pc, base + 32'd8);
    check("t4_b_pc", b_pc, base + 32'd12);

    // Flush at count 5 discards the same-cycle push and consume
    cyc(2'd2, base + 32'd16, base + 32'd20, 2'd0, 1'b0);
    cyc(2'd1, base + 32'd24, 32'hdeadbeef, 2'd0, 1'b0);
    check("t5_pre_a_pc", a_pc, base + 32'd8);
    cyc(2'd2, 32'h1c000f00, 32'h1c000f04, 2'd1, 1'b1);
    check("t5_flush_a_valid", 32'(a_valid), 32'd0);
    check("t5_flush_b_valid", 32'(b_valid), 32'd0);
    check("t5_flush_allowin", 32'(iq_allowin), 32'd1);
    cyc(2'd1, 32'h1c001000, 32'hdeadbeef, 2'd0, 1'b0);
    check("t5_post_a_valid", 32'(a_valid), 32'd1);
    check("t5_post_b_valid", 32'(b_valid), 32'd0);
    check("t5_post_a_pc", a_pc, 32'h1c001000);

    // Exception / prediction fields pass through verbatim
    if_a_have_exception     = 1'b1;
    if_a_exception_type     = ADEF;
    if_a_pred_branch_taken  = 1'b1;
    if_a_pred_branch_target = 32'h1c000100;
    cyc(2'd1, 32'h1c002000, 32'h0, 2'd1, 1'b0);
    check("t6_a_pc", a_pc, 32'h1c002000);
    check("t6_a_inst", a_inst, inst_of(32'h1c002000));
    check("t6_a_have_exc", 32'(a_have_exception), 32'd1);
    check("t6_a_exc_type", 32'(a_exception_type), 32'(ADEF));
    check("t6_a_pred_taken", 32'(a_pred_branch_taken), 32'd1);
    check("t6_a_pred_target", a_pred_branch_target, 32'h1c000100);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_a_valid", 32'(a_valid), 32'd0);
    check("t6_rst_a_pc", a_pc, 32'd0);
    check("t6_rst_a_have_exc", 32'(a_have_exception), 32'd0);
    check("t6_rst_a_pred_target", a_pred_branch_target, 32'd0);
    check("t6_rst_b_pc", b_pc, 32'd0);
    check("t6_rst_allowin", 32'(iq_allowin), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
